// File: rtl/iob_ram_t2p_rd_stream.sv
// iob_ram_t2p_rd_stream: sequential RAM read engine feeding a valid/ready stream
// through a 3-entry buffer that absorbs the 1-cycle RAM read latency.
module iob_ram_t2p_rd_stream #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4,
  parameter int LEN_W  = ADDR_W + 1
) (
  input  logic              clk_i,
  input  logic              arst_i,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] start_addr_i,
  input  logic [LEN_W-1:0]  len_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              r_en_o,
  output logic [ADDR_W-1:0] r_addr_o,
  input  logic [DATA_W-1:0] r_data_i,
  output logic              m_valid_o,
  output logic [DATA_W-1:0] m_data_o,
  input  logic              m_ready_i
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [LEN_W-1:0] len_q, issued_q, delivered_q, delivered_d;
  logic inflight_q;
  logic [1:0] occ_q, wr_q, rd_q;
  logic [DATA_W-1:0] fifo_q [3];
  logic start, push, pop;

  function automatic logic [1:0] inc3(input logic [1:0] p);
    return p == 2'd2 ? 2'd0 : p + 2'd1;
  endfunction

  assign start       = state_q == IDLE && start_i;
  assign push        = inflight_q;
  assign pop         = m_valid_o && m_ready_i;
  assign delivered_d = delivered_q + LEN_W'(pop);
  assign r_addr_o    = addr_q;
  assign m_valid_o   = occ_q != 2'd0;
  assign m_data_o    = fifo_q[rd_q];

  always_ff @(posedge clk_i or posedge arst_i)
    if (arst_i) state_q <= IDLE;
    else        state_q <= state_d;

  // Counting the current handshake lets DONE follow the final pop directly.
  always_comb
    state_d = state_q == IDLE ? (start_i ? RUN : IDLE) :
              state_q == RUN  ? (delivered_d == len_q ? DONE : RUN) : IDLE;

  always_comb begin
    busy_o = state_q == RUN;
    done_o = state_q == DONE;
    r_en_o = busy_o && issued_q < len_q && ({1'b0, occ_q} + {2'b0, inflight_q}) < 3'd3;
  end

  always_ff @(posedge clk_i or posedge arst_i)
    if (arst_i) begin
      addr_q      <= '0;
      len_q       <= '0;
      issued_q    <= '0;
      delivered_q <= '0;
      inflight_q  <= 1'b0;
      occ_q       <= 2'd0;
      wr_q        <= 2'd0;
      rd_q        <= 2'd0;
      for (int i = 0; i < 3; i++) fifo_q[i] <= '0;
    end else begin
      if (start) begin
        addr_q      <= start_addr_i;
        len_q       <= len_i;
        issued_q    <= '0;
        delivered_q <= '0;
      end else begin
        if (r_en_o) begin
          addr_q   <= addr_q + 1'b1;
          issued_q <= issued_q + 1'b1;
        end
        delivered_q <= delivered_d;
      end
      inflight_q <= r_en_o;
      if (push) begin
        fifo_q[wr_q] <= r_data_i;
        wr_q         <= inc3(wr_q);
      end
      if (pop) rd_q <= inc3(rd_q);
      occ_q <= occ_q + {1'b0, push} - {1'b0, pop};
    end
endmodule

// File: tb/tb_iob_ram_t2p_rd_stream.sv
// tb_iob_ram_t2p_rd_stream: scoreboard bench with a 1-cycle RAM model.
module tb_iob_ram_t2p_rd_stream;
  localparam int DW = 8, AW = 4, LW = 5;
  logic clk = 1'b0, arst_i = 1'b1, start_i = 1'b0, m_ready_i = 1'b0;
  logic [AW-1:0] start_addr_i = '0;
  logic [LW-1:0] len_i = '0;
  logic busy_o, done_o, r_en_o, m_valid_o;
  logic [AW-1:0] r_addr_o;
  logic [DW-1:0] r_data_i, m_data_o;
  logic [DW-1:0] mem [16];
  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] held_d, e;
  logic held_v = 1'b0;
  int tests = 0, fails = 0;
  int r_hs, r_ren, r_ren_early, r_done_n, r_done_cyc, r_first_hs, r_last_hs;
  logic r_busy1, r_ren1;
  logic [AW-1:0] r_addr1;
  logic [AW-1:0] a_log [$];
  logic [DW-1:0] d_log [$];

  iob_ram_t2p_rd_stream #(.DATA_W(DW), .ADDR_W(AW), .LEN_W(LW)) dut (
    .clk_i(clk), .arst_i(arst_i), .start_i(start_i), .start_addr_i(start_addr_i),
    .len_i(len_i), .busy_o(busy_o), .done_o(done_o), .r_en_o(r_en_o),
    .r_addr_o(r_addr_o), .r_data_i(r_data_i), .m_valid_o(m_valid_o),
    .m_data_o(m_data_o), .m_ready_i(m_ready_i)
  );

  always #5 clk = ~clk;
  initial for (int i = 0; i < 16; i++) mem[i] = DW'(i + 32);
  always @(posedge clk) if (r_en_o) r_data_i <= mem[r_addr_o];

  // Scoreboard: expected word queued on issue, compared on handshake.
  always @(negedge clk) if (!arst_i) begin
    if (held_v && m_valid_o) begin
      tests++;
      if (m_data_o !== held_d) begin fails++; $display("FAIL stall_hold: got %0d want %0d", m_data_o, held_d); end
    end
    held_v = m_valid_o && !m_ready_i;
    held_d = m_data_o;
    if (m_valid_o && m_ready_i) begin
      tests++;
      if (exp_q.size() == 0) begin fails++; $display("FAIL extra_word: got %0d want none", m_data_o); end
      else begin
        e = exp_q.pop_front();
        if (m_data_o !== e) begin fails++; $display("FAIL stream_data: got %0d want %0d", m_data_o, e); end
      end
    end
    if (r_en_o) begin
      exp_q.push_back(mem[r_addr_o]);
      tests++;
      if (exp_q.size() > 3) begin fails++; $display("FAIL outstanding: got %0d want <=3", exp_q.size()); end
    end
  end

  task automatic run(input logic [AW-1:0] a, input logic [LW-1:0] n, input int mode, input int rk);
    bit fin = 0;
    r_hs = 0; r_ren = 0; r_ren_early = 0; r_done_n = 0; r_done_cyc = -1; r_first_hs = -1; r_last_hs = -1;
    a_log.delete(); d_log.delete();
    @(posedge clk); #1 start_i = 1'b1; start_addr_i = a; len_i = n; m_ready_i = 1'b1;
    @(posedge clk); #1 start_i = 1'b0;
    for (int k = 1; k <= 200 && !fin; k++) begin
      start_i = (k == rk);
      m_ready_i = mode == 0 ? 1'b1 : k < 3 ? 1'b1 : k <= 8 ? 1'b0 : (k % 2 == 1);
      @(negedge clk);
      if (k == 1) begin r_busy1 = busy_o; r_ren1 = r_en_o; r_addr1 = r_addr_o; end
      if (r_en_o) begin r_ren++; a_log.push_back(r_addr_o); if (k <= 8) r_ren_early++; end
      if (m_valid_o && m_ready_i) begin
        r_hs++; d_log.push_back(m_data_o);
        if (r_first_hs < 0) r_first_hs = k;
        r_last_hs = k;
      end
      if (done_o) begin r_done_n++; r_done_cyc = k; end
      if (r_done_n > 0 && !done_o && !busy_o) fin = 1;
      else begin @(posedge clk); #1; end
    end
    start_i = 1'b0; m_ready_i = 1'b1;
    tests++;
    if (!fin) begin fails++; $display("FAIL run_timeout: got busy=%0d want idle", busy_o); end
  endtask

  task automatic test_reset();
    #12;
    tests++;
    if ({busy_o, done_o, r_en_o, m_valid_o, r_addr_o, m_data_o} !== '0) begin
      fails++; $display("FAIL reset_outputs: got %0h want 0", {busy_o, done_o, r_en_o, m_valid_o, r_addr_o, m_data_o});
    end
    @(posedge clk); #1 arst_i = 1'b0;
    @(negedge clk);
    tests++;
    if ({busy_o, done_o, r_en_o, m_valid_o} !== 4'b0) begin
      fails++; $display("FAIL idle_after_reset: got %0b want 0", {busy_o, done_o, r_en_o, m_valid_o});
    end
  endtask

  task automatic test_full();
    run(4'd0, 5'd16, 0, 0);
    tests++; if (d_log.size() != 16) begin fails++; $display("FAIL full_count: got %0d want 16", d_log.size()); end
    for (int i = 0; i < 16 && i < d_log.size(); i++) begin
      tests++;
      if (d_log[i] !== DW'(32 + i)) begin fails++; $display("FAIL full_data[%0d]: got %0d want %0d", i, d_log[i], 32 + i); end
    end
    tests++; if (r_ren != 16) begin fails++; $display("FAIL full_reads: got %0d want 16", r_ren); end
    tests++; if (r_first_hs != 3 || r_last_hs != 18) begin fails++; $display("FAIL full_hs_window: got %0d..%0d want 3..18", r_first_hs, r_last_hs); end
    tests++; if (r_done_cyc != 19 || r_done_n != 1) begin fails++; $display("FAIL full_done: got cyc %0d n %0d want cyc 19 n 1", r_done_cyc, r_done_n); end
    tests++; if (!r_busy1 || !r_ren1 || r_addr1 !== 4'd0) begin fails++; $display("FAIL full_cycle1: got busy %0d ren %0d addr %0d want 1 1 0", r_busy1, r_ren1, r_addr1); end
  endtask

  task automatic test_wrap();
    logic [AW-1:0] ea [4];
    ea[0] = 4'd14; ea[1] = 4'd15; ea[2] = 4'd0; ea[3] = 4'd1;
    run(4'd14, 5'd4, 0, 0);
    tests++; if (a_log.size() != 4 || d_log.size() != 4) begin fails++; $display("FAIL wrap_count: got %0d/%0d want 4/4", a_log.size(), d_log.size()); end
    for (int i = 0; i < 4 && i < a_log.size() && i < d_log.size(); i++) begin
      tests++;
      if (a_log[i] !== ea[i] || d_log[i] !== DW'(32 + ea[i])) begin
        fails++; $display("FAIL wrap[%0d]: got addr %0d data %0d want addr %0d data %0d", i, a_log[i], d_log[i], ea[i], 32 + ea[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    run(4'd0, 5'd8, 1, 0);
    tests++; if (r_ren_early != 3) begin fails++; $display("FAIL bp_stall_reads: got %0d want 3", r_ren_early); end
    tests++; if (d_log.size() != 8 || r_ren != 8) begin fails++; $display("FAIL bp_count: got %0d words %0d reads want 8", d_log.size(), r_ren); end
    for (int i = 0; i < 8 && i < d_log.size(); i++) begin
      tests++;
      if (d_log[i] !== DW'(32 + i)) begin fails++; $display("FAIL bp_data[%0d]: got %0d want %0d", i, d_log[i], 32 + i); end
    end
    tests++; if (r_done_n != 1) begin fails++; $display("FAIL bp_done: got %0d want 1", r_done_n); end
  endtask

  task automatic test_zero_and_ignored_start();
    int busy_seen = 0;
    run(4'd0, 5'd0, 0, 0);
    tests++; if (r_ren != 0 || r_hs != 0) begin fails++; $display("FAIL zero_reads: got %0d reads %0d words want 0", r_ren, r_hs); end
    tests++; if (r_done_cyc != 2 || !r_busy1) begin fails++; $display("FAIL zero_timing: got done cyc %0d busy1 %0d want 2 1", r_done_cyc, r_busy1); end
    run(4'd0, 5'd5, 0, 2);
    tests++; if (r_hs != 5 || r_done_n != 1) begin fails++; $display("FAIL ignored_start: got %0d words %0d done want 5 1", r_hs, r_done_n); end
    for (int i = 0; i < 5 && i < d_log.size(); i++) begin
      tests++;
      if (d_log[i] !== DW'(32 + i)) begin fails++; $display("FAIL ign_data[%0d]: got %0d want %0d", i, d_log[i], 32 + i); end
    end
    for (int k = 0; k < 3; k++) begin @(negedge clk); if (busy_o) busy_seen++; end
    tests++; if (busy_seen != 0) begin fails++; $display("FAIL start_queued: got %0d busy cycles want 0", busy_seen); end
  endtask

  task automatic test_reset_mid_run();
    int n = 0, dn = 0;
    @(posedge clk); #1 start_i = 1'b1; start_addr_i = 4'd0; len_i = 5'd16; m_ready_i = 1'b1;
    @(posedge clk); #1 start_i = 1'b0;
    for (int k = 0; k < 50 && n < 5; k++) begin
      @(negedge clk);
      if (m_valid_o && m_ready_i) n++;
      if (done_o) dn++;
    end
    tests++; if (n != 5) begin fails++; $display("FAIL mid_words: got %0d want 5", n); end
    #2 arst_i = 1'b1;
    #1;
    exp_q.delete(); held_v = 1'b0;
    tests++;
    if ({busy_o, done_o, r_en_o, m_valid_o, r_addr_o, m_data_o} !== '0) begin
      fails++; $display("FAIL mid_reset_outputs: got %0h want 0", {busy_o, done_o, r_en_o, m_valid_o, r_addr_o, m_data_o});
    end
    for (int k = 0; k < 4; k++) begin @(negedge clk); if (done_o) dn++; end
    @(posedge clk); #1 arst_i = 1'b0;
    for (int k = 0; k < 3; k++) begin @(negedge clk); if (done_o) dn++; end
    tests++; if (dn != 0) begin fails++; $display("FAIL mid_no_done: got %0d want 0", dn); end
    run(4'd3, 5'd2, 0, 0);
    tests++;
    if (d_log.size() != 2 || d_log[0] !== 8'd35 || d_log[1] !== 8'd36) begin
      fails++; $display("FAIL restart_data: got %0d words want 35,36", d_log.size());
    end
  endtask

  initial begin
    test_reset();
    test_full();
    test_wrap();
    test_backpressure();
    test_zero_and_ignored_start();
    test_reset_mid_run();
    tests++;
    if (exp_q.size() != 0) begin fails++; $display("FAIL leftover: got %0d want 0", exp_q.size()); end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1);
  end
endmodule
